// File: rtl/mux_channel_scanner_if.sv
// Handshake and data bundle between the channel scanner, its controller and the 4:1 mux stage.
// The master side is the controller/mux pair; the slave side is the scanner itself.
interface mux_channel_scanner_if;
    localparam int unsigned VEC_W = 4;
    localparam int unsigned CNT_W = 8;

    logic             start;
    logic             mode;
    logic             abort;
    logic             y;
    logic             s1;
    logic             s0;
    logic             busy;
    logic             done;
    logic [VEC_W-1:0] sample_vec;
    logic [CNT_W-1:0] scan_cnt;

    modport master (
        output start, mode, abort, y,
        input  s1, s0, busy, done, sample_vec, scan_cnt
    );

    modport slave (
        input  start, mode, abort, y,
        output s1, s0, busy, done, sample_vec, scan_cnt
    );
endinterface

// File: rtl/mux_channel_scanner.sv
// Sequencer for the 4:1 mux stage: walks the select through channels 0..3, lets each one
// settle for DWELL cycles, samples y once per channel and publishes the packed result with a
// one-cycle done pulse. Runs single-shot or back-to-back; abort drops back to IDLE at once.
module mux_channel_scanner #(
    parameter int unsigned DWELL = 2,
    parameter int unsigned CNT_W = 4
) (
    input logic                  clk,
    input logic                  rst_n,
    mux_channel_scanner_if.slave bus
);

    localparam int unsigned VEC_W  = 4;
    localparam int unsigned SCAN_W = 8;
    localparam int unsigned CH_W   = 2;

    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);
    localparam logic [CH_W-1:0]  CH_LAST    = CH_W'(VEC_W - 1);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        SAMPLE,
        DONE
    } state_t;

    state_t              state;
    logic [CNT_W-1:0]    dwell_cnt;
    logic [CH_W-1:0]     ch;
    logic [VEC_W-2:0]    shadow;
    logic                s1_q;
    logic                s0_q;
    logic                busy_q;
    logic                done_q;
    logic [VEC_W-1:0]    vec_q;
    logic [SCAN_W-1:0]   scan_q;

    assign bus.s1         = s1_q;
    assign bus.s0         = s0_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.sample_vec = vec_q;
    assign bus.scan_cnt   = scan_q;

    // Scan sequencer: state, channel/dwell tracking and every registered output.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            dwell_cnt <= '0;
            ch        <= '0;
            shadow    <= '0;
            s1_q      <= 1'b0;
            s0_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            vec_q     <= '0;
            scan_q    <= '0;
        end else begin
            done_q <= 1'b0;

            if ((state != IDLE) && bus.abort) begin
                // Partial samples are dropped; published results stay untouched.
                state     <= IDLE;
                dwell_cnt <= '0;
                ch        <= '0;
                shadow    <= '0;
                s1_q      <= 1'b0;
                s0_q      <= 1'b0;
                busy_q    <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        s1_q <= 1'b0;
                        s0_q <= 1'b0;
                        if (bus.start && !bus.abort) begin
                            state     <= SETTLE;
                            ch        <= '0;
                            dwell_cnt <= '0;
                            busy_q    <= 1'b1;
                        end
                    end

                    SETTLE: begin
                        if (dwell_cnt == DWELL_LAST) begin
                            state <= SAMPLE;
                        end else begin
                            dwell_cnt <= dwell_cnt + CNT_W'(1);
                        end
                    end

                    SAMPLE: begin
                        if (ch != CH_LAST) begin
                            // Capture this channel and move the select on the same edge.
                            unique case (ch)
                                2'd0:    shadow[0] <= bus.y;
                                2'd1:    shadow[1] <= bus.y;
                                default: shadow[2] <= bus.y;
                            endcase
                            ch        <= ch + CH_W'(1);
                            {s1_q, s0_q} <= ch + CH_W'(1);
                            dwell_cnt <= '0;
                            state     <= SETTLE;
                        end else begin
                            vec_q  <= {bus.y, shadow};
                            scan_q <= scan_q + SCAN_W'(1);
                            done_q <= 1'b1;
                            state  <= DONE;
                        end
                    end

                    DONE: begin
                        ch        <= '0;
                        dwell_cnt <= '0;
                        s1_q      <= 1'b0;
                        s0_q      <= 1'b0;
                        if (bus.mode) begin
                            state <= SETTLE;
                        end else begin
                            state  <= IDLE;
                            busy_q <= 1'b0;
                        end
                    end

                    default: begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Handshake sanity: done is a lone pulse and only ever seen while busy.
    always @(posedge clk) begin
        if (rst_n) begin
            assert (!done_q || busy_q);
        end
    end

endmodule

// File: tb/tb_mux_channel_scanner.sv
// Self-checking bench for mux_channel_scanner (DWELL=2). The mux stage is modelled as
// y = I[{s1,s0}]; expectations come from the scan timing rules and a simple scan counter.
module tb_mux_channel_scanner;

    localparam int unsigned DWELL   = 2;
    localparam int unsigned CH_CYC  = DWELL + 1;
    localparam int unsigned SCAN_CY = 4 * CH_CYC + 1;

    logic clk;
    logic rst_n;
    logic [3:0] data;

    int checks;
    int errors;
    int model_cnt;
    logic [3:0] last_vec;

    mux_channel_scanner_if bif ();

    mux_channel_scanner #(.DWELL(DWELL), .CNT_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif.slave)
    );

    // Behavioural 4:1 mux: I0..I3 are data[0]..data[3].
    assign bif.y = data[{bif.s1, bif.s0}];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag, input logic [3:0] vec, input int cnt);
        check({tag, "_busy"}, 32'(bif.busy), 32'd0);
        check({tag, "_done"}, 32'(bif.done), 32'd0);
        check({tag, "_sel"}, 32'({bif.s1, bif.s0}), 32'd0);
        check({tag, "_vec"}, 32'(bif.sample_vec), 32'(vec));
        check({tag, "_cnt"}, 32'(bif.scan_cnt), 32'(cnt));
    endtask

    // Called in cycle 1 of a scan; returns in the cycle after its done cycle.
    task automatic track_scan(input logic [3:0] d, input string tag);
        for (int c = 1; c <= SCAN_CY; c++) begin
            if (c < SCAN_CY) begin
                check({tag, "_sel"}, 32'({bif.s1, bif.s0}), 32'((c - 1) / CH_CYC));
            end
            check({tag, "_busy"}, 32'(bif.busy), 32'd1);
            check({tag, "_done"}, 32'(bif.done), 32'(c == SCAN_CY));
            if (c == SCAN_CY) begin
                model_cnt = (model_cnt + 1) % 256;
                last_vec  = d;
                check({tag, "_vec"}, 32'(bif.sample_vec), 32'(d));
                check({tag, "_cnt"}, 32'(bif.scan_cnt), 32'(model_cnt));
                bif.start = 1'b0;
            end
            tick();
        end
    endtask

    task automatic pulse_start();
        bif.start = 1'b1;
        tick();
        bif.start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            if (bif.done === 1'b1) seen = 1'b1;
            else tick();
        end
    endtask

    initial begin
        logic [3:0] d;
        logic [3:0] pat [16];
        bit seen;

        checks    = 0;
        errors    = 0;
        model_cnt = 0;
        last_vec  = 4'd0;
        data      = 4'd0;
        bif.start = 1'b0;
        bif.mode  = 1'b0;
        bif.abort = 1'b0;
        rst_n     = 1'b0;
        tick();
        tick();
        check_idle("reset_init", 4'd0, 0);
        rst_n = 1'b1;
        tick();
        check_idle("post_reset", 4'd0, 0);

        // Reset in the middle of a continuous scan.
        bif.mode = 1'b1;
        data = 4'b1010;
        pulse_start();
        track_scan(4'b1010, "cont_pre_rst");
        for (int i = 0; i < 4; i++) tick();
        check("midscan_busy", 32'(bif.busy), 32'd1);
        rst_n = 1'b0;
        tick();
        check_idle("rst_mid1", 4'd0, 0);
        tick();
        check_idle("rst_mid2", 4'd0, 0);
        rst_n = 1'b1;
        bif.mode = 1'b0;
        model_cnt = 0;
        last_vec = 4'd0;
        tick();
        check_idle("rst_release", 4'd0, 0);

        // Single scan, I0..I3 = 1,0,1,1.
        data = 4'b1101;
        pulse_start();
        track_scan(4'b1101, "single");
        check_idle("single_after", 4'b1101, 1);

        // Continuous: two back-to-back scans, data and mode changed between them.
        d = 4'($urandom);
        data = d;
        bif.mode = 1'b1;
        pulse_start();
        track_scan(d, "cont1");
        data = 4'b0110;
        bif.mode = 1'b0;
        track_scan(4'b0110, "cont2");
        check_idle("cont_after", 4'b0110, model_cnt);

        // Abort during channel-2 settle.
        data = 4'($urandom);
        pulse_start();
        for (int i = 1; i < 2 * CH_CYC + 1; i++) tick();
        check("abort_ch2_sel", 32'({bif.s1, bif.s0}), 32'd2);
        bif.abort = 1'b1;
        tick();
        bif.abort = 1'b0;
        check_idle("abort_settle", last_vec, model_cnt);
        for (int i = 0; i < SCAN_CY; i++) begin
            check("abort_no_done", 32'(bif.done), 32'd0);
            tick();
        end

        // Abort while in DONE of a continuous scan.
        d = 4'($urandom);
        data = d;
        bif.mode = 1'b1;
        pulse_start();
        for (int i = 1; i < SCAN_CY; i++) tick();
        model_cnt = (model_cnt + 1) % 256;
        last_vec = d;
        check("abort_done_pulse", 32'(bif.done), 32'd1);
        bif.abort = 1'b1;
        tick();
        bif.abort = 1'b0;
        bif.mode = 1'b0;
        check_idle("abort_in_done", d, model_cnt);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("abort_done_stays_idle", 32'(bif.busy), 32'd0);
        end

        // start held high through a whole scan produces exactly one scan.
        data = 4'($urandom);
        bif.start = 1'b1;
        tick();
        track_scan(data, "start_held");
        for (int i = 0; i < 5; i++) begin
            check("held_one_scan_busy", 32'(bif.busy), 32'd0);
            tick();
        end

        // start together with abort in IDLE is ignored.
        bif.start = 1'b1;
        bif.abort = 1'b1;
        tick();
        bif.start = 1'b0;
        bif.abort = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check_idle("start_abort", last_vec, model_cnt);
            tick();
        end

        // 256 single scans: counter wraps through 255 -> 0.
        for (int n = 0; n < 256; n++) begin
            d = 4'($urandom);
            data = d;
            pulse_start();
            wait_done(SCAN_CY + 4, seen);
            check("wrap_done_seen", 32'(seen), 32'd1);
            model_cnt = (model_cnt + 1) % 256;
            last_vec = d;
            check("wrap_vec", 32'(bif.sample_vec), 32'(d));
            check("wrap_cnt", 32'(bif.scan_cnt), 32'(model_cnt));
            if (model_cnt == 0) check("wrap_zero", 32'(bif.scan_cnt), 32'd0);
            tick();
        end

        // All 16 input patterns in shuffled order.
        for (int i = 0; i < 16; i++) pat[i] = 4'(i);
        for (int i = 15; i > 0; i--) begin
            int j;
            j = int'($urandom_range(i, 0));
            d = pat[i];
            pat[i] = pat[j];
            pat[j] = d;
        end
        for (int i = 0; i < 16; i++) begin
            data = pat[i];
            pulse_start();
            track_scan(pat[i], "pattern");
            check("pattern_idle", 32'(bif.busy), 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
